cpu_clk_ctrl: RTL and testbench

Clock-enable sequencer for the single-cycle processor. It replaces the free-running divided clock with a single-cycle `cpu_ce` enable on the board clock domain. It offers free-run, single-step, idle and halted modes, a runtime-programmable divide ratio, and a retired-cycle counter for the debug display. It sits between the board clock/switch inputs and every state element of the processor (PC, register file, data memory write).

---
 rtl/cpu_clk_ctrl.sv | 114 +++++++++++
 tb/tb_cpu_clk_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl -- clock-enable sequencer for the single-cycle processor.
//
// Produces a one-clock cpu_ce pulse on the board clock instead of a divided
// clock. Modes: IDLE (stopped), RUN (free-run every DIV+1 clocks), STEP
// (exactly one pulse per step button edge) and HALTED (stopped by the
// processor's halt instruction until the run switch is dropped).
//
// Ports:
//   clk        board clock, the only clock
//   rst        asynchronous active-high reset
//   run_en     level, request free-run
//   step_req   level from debounced button; each rising edge asks for one cycle
//   halt_req   level from the processor, stops free-run
//   div_load   one-cycle strobe, loads div_val into the divide register
//   div_val    new divide ratio (pulse period is div_val+1 clocks)
//   cpu_ce     registered one-clock enable for every processor state element
//   state      IDLE=00 RUN=01 STEP=10 HALTED=11
//   busy       high in RUN or STEP
//   cycle_cnt  number of cpu_ce pulses issued, wraps silently
module cpu_clk_ctrl #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 24,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    state_t           cur_state, nxt_state;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] count, count_nxt;
    logic             step_q;
    logic             step_edge;
    logic             tick;
    logic             ce_nxt;

    assign step_edge = step_req & ~step_q;
    assign tick      = (count == div_reg);
    assign state     = cur_state;
    assign busy      = (cur_state == S_RUN) | (cur_state == S_STEP);

    // Next state and next enable. A div_load in the same cycle as a tick
    // swallows that tick, so STEP keeps waiting for a tick at the new ratio.
    always_comb begin
        nxt_state = cur_state;
        ce_nxt    = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (run_en)         nxt_state = S_RUN;
                else if (step_edge) nxt_state = S_STEP;
            end
            S_RUN: begin
                if (halt_req)       nxt_state = S_HALTED;
                else if (!run_en)   nxt_state = S_IDLE;
                else                ce_nxt    = tick & ~div_load;
            end
            S_STEP: begin
                if (tick && !div_load) begin
                    ce_nxt    = 1'b1;
                    nxt_state = S_IDLE;
                end
            end
            S_HALTED: begin
                if (!run_en)        nxt_state = S_IDLE;
            end
        endcase
    end

    // Prescaler: restarts from 0 on a ratio load, on any state change (so
    // every RUN/STEP entry starts a full period) and after each tick; it
    // sits at 0 whenever the sequencer is not counting.
    always_comb begin
        count_nxt = count + DIV_W'(1);
        if (div_load || (nxt_state != cur_state) || tick ||
            !((nxt_state == S_RUN) || (nxt_state == S_STEP)))
            count_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
            div_reg   <= DIV_W'(DEFAULT_DIV);
            count     <= '0;
            step_q    <= 1'b0;
            cpu_ce    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            count     <= count_nxt;
            step_q    <= step_req;
            cpu_ce    <= ce_nxt;
            cycle_cnt <= cycle_cnt + CNT_W'(cpu_ce);
            if (div_load)
                div_reg <= div_val;
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl. A second instance with a 4-bit
// retired-cycle counter shares all inputs to exercise counter wrap.
// Reference model: mode number plus "clocks since the period restarted";
// a pulse is due whenever that elapsed count is D modulo D+1.
module tb_cpu_clk_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_en = 1'b0, step_req = 1'b0, halt_req = 1'b0, div_load = 1'b0;
    logic [15:0] div_val = '0;

    logic        cpu_ce, busy, ce4, busy4;
    logic [1:0]  state, st4;
    logic [31:0] cycle_cnt;
    logic [3:0]  cnt4;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [1:0]  m_mode;
    int          m_since;
    int          m_div;
    logic        m_ce;
    logic [31:0] m_cnt;
    logic        m_prev;

    cpu_clk_ctrl u_dut (
        .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req),
        .halt_req(halt_req), .div_load(div_load), .div_val(div_val),
        .cpu_ce(cpu_ce), .state(state), .busy(busy), .cycle_cnt(cycle_cnt)
    );

    cpu_clk_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req),
        .halt_req(halt_req), .div_load(div_load), .div_val(div_val),
        .cpu_ce(ce4), .state(st4), .busy(busy4), .cycle_cnt(cnt4)
    );

    always #5 clk = ~clk;

    wire [43:0] dut_vec = {cpu_ce, state, busy, cycle_cnt, ce4, st4, busy4, cnt4};

    function automatic logic [43:0] model_vec();
        logic b;
        b = (m_mode == 2'd1) || (m_mode == 2'd2);
        return {m_ce, m_mode, b, m_cnt, m_ce, m_mode, b, m_cnt[3:0]};
    endfunction

    task automatic model_reset();
        m_mode = 2'd0; m_since = 0; m_div = 24; m_ce = 1'b0; m_cnt = '0; m_prev = 1'b0;
    endtask

    // One clock: advance the model on the edge from the inputs held across it,
    // then step 1 time unit past the edge so outputs can be sampled.
    task automatic cyc();
        logic       se, tk, nce;
        logic [1:0] nm;
        @(posedge clk);
        se  = step_req & ~m_prev;
        tk  = ((m_mode == 2'd1) || (m_mode == 2'd2)) && ((m_since % (m_div + 1)) == m_div);
        nce = 1'b0;
        nm  = m_mode;
        case (m_mode)
            2'd0: if (run_en) nm = 2'd1; else if (se) nm = 2'd2;
            2'd1: if (halt_req) nm = 2'd3; else if (!run_en) nm = 2'd0;
                  else if (tk && !div_load) nce = 1'b1;
            2'd2: if (tk && !div_load) begin nce = 1'b1; nm = 2'd0; end
            default: if (!run_en) nm = 2'd0;
        endcase
        m_cnt = m_cnt + {31'd0, m_ce};
        if (div_load) begin
            m_div   = int'(div_val);
            m_since = 0;
        end else if (nm != m_mode) begin
            m_since = 0;
        end else if ((nm == 2'd1) || (nm == 2'd2)) begin
            m_since = m_since + 1;
        end
        m_ce   = nce;
        m_mode = nm;
        m_prev = step_req;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run_en = 1'b0; step_req = 1'b0; halt_req = 1'b0; div_load = 1'b0; div_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_div(input logic [15:0] d);
        div_val = d; div_load = 1'b1;
        cyc();
        div_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run_en = 1'b1; step_req = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (state !== 2'b00)     begin bad++; $display("FAIL reset_state got=%b want=00", state); end
        total++; if (cpu_ce !== 1'b0)     begin bad++; $display("FAIL reset_ce got=%b want=0", cpu_ce); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cycle_cnt); end
        total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL reset_model got=%h want=%h", dut_vec, model_vec()); end
        run_en = 1'b0; step_req = 1'b0;
    endtask

    task automatic test_run_free();
        do_reset();
        run_en = 1'b1;
        cyc();  // entry edge
        total++; if (state !== 2'b01) begin bad++; $display("FAIL run_entry got=%b want=01", state); end
        for (int k = 1; k <= 101; k++) begin
            cyc();
            total++; if (cpu_ce !== ((k % 25) == 0)) begin bad++; $display("FAIL run_period k=%0d got=%b", k, cpu_ce); end
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL run_model k=%0d got=%h want=%h", k, dut_vec, model_vec()); end
        end
        total++; if (cycle_cnt !== 32'd4) begin bad++; $display("FAIL run_count got=%0d want=4", cycle_cnt); end
    endtask

    task automatic test_step();
        int pulses;
        do_reset();
        load_div(16'd3);
        step_req = 1'b1;
        cyc();  // edge sampled
        total++; if (state !== 2'b10) begin bad++; $display("FAIL step_entry got=%b want=10", state); end
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (cpu_ce === 1'b1) pulses++;
            total++; if (cpu_ce !== (k == 4)) begin bad++; $display("FAIL step_pulse k=%0d got=%b", k, cpu_ce); end
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL step_model k=%0d got=%h want=%h", k, dut_vec, model_vec()); end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL step_once got=%0d want=1", pulses); end
        total++; if (cycle_cnt !== 32'd1) begin bad++; $display("FAIL step_cnt got=%0d want=1", cycle_cnt); end
        step_req = 1'b0;
        cyc();
        step_req = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            cyc();
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL step2_model k=%0d got=%h want=%h", k, dut_vec, model_vec()); end
        end
        total++; if (cycle_cnt !== 32'd2) begin bad++; $display("FAIL step2_cnt got=%0d want=2", cycle_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        load_div(16'd0);
        run_en = 1'b1;
        cyc();
        for (int k = 1; k <= 8; k++) begin
            cyc();
            total++; if (cpu_ce !== 1'b1) begin bad++; $display("FAIL halt_run k=%0d got=%b want=1", k, cpu_ce); end
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL halt_model k=%0d got=%h want=%h", k, dut_vec, model_vec()); end
        end
        halt_req = 1'b1;
        cyc();
        total++; if (cpu_ce !== 1'b0)  begin bad++; $display("FAIL halt_ce got=%b want=0", cpu_ce); end
        total++; if (state !== 2'b11)  begin bad++; $display("FAIL halt_state got=%b want=11", state); end
        halt_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step_req = k[0];
            cyc();
            total++; if (state !== 2'b11 || cpu_ce !== 1'b0) begin bad++; $display("FAIL halt_step k=%0d got st=%b ce=%b want st=11 ce=0", k, state, cpu_ce); end
        end
        step_req = 1'b0; run_en = 1'b0;
        cyc();
        total++; if (state !== 2'b00) begin bad++; $display("FAIL halt_rearm got=%b want=00", state); end
        total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL halt_end got=%h want=%h", dut_vec, model_vec()); end
    endtask

    task automatic test_reprogram();
        do_reset();
        run_en = 1'b1;
        cyc();
        for (int k = 1; k <= 10; k++) cyc();
        div_val = 16'd1; div_load = 1'b1;
        cyc();
        total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL reprog_load got=%b want=0", cpu_ce); end
        div_load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            total++; if (cpu_ce !== ((k % 2) == 0)) begin bad++; $display("FAIL reprog_period k=%0d got=%b", k, cpu_ce); end
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL reprog_model k=%0d got=%h want=%h", k, dut_vec, model_vec()); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_div(16'd100);
        step_req = 1'b1;
        cyc();
        for (int k = 1; k <= 50; k++) cyc();
        total++; if (state !== 2'b10) begin bad++; $display("FAIL arst_pre got=%b want=10", state); end
        #3 rst = 1'b1;
        #1;
        total++; if (cpu_ce !== 1'b0 || state !== 2'b00 || busy !== 1'b0) begin
            bad++; $display("FAIL arst_now got ce=%b st=%b busy=%b want 0/00/0", cpu_ce, state, busy); end
        model_reset();
        step_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            cyc();
            total++; if (cpu_ce !== 1'b0 || state !== 2'b00) begin bad++; $display("FAIL arst_quiet k=%0d got ce=%b st=%b", k, cpu_ce, state); end
        end
        run_en = 1'b1;
        cyc();
        for (int k = 1; k <= 50; k++) begin
            cyc();
            total++; if (cpu_ce !== ((k % 25) == 0)) begin bad++; $display("FAIL arst_div k=%0d got=%b", k, cpu_ce); end
        end
    endtask

    task automatic test_wrap();
        int pulses;
        int guard;
        do_reset();
        load_div(16'd0);
        run_en = 1'b1;
        cyc();
        pulses = 0; guard = 0;
        while (pulses < 17 && guard < 100) begin
            cyc();
            guard++;
            if (cpu_ce === 1'b1) pulses++;
        end
        total++; if (pulses != 17) begin bad++; $display("FAIL wrap_timeout got=%0d want=17", pulses); end
        run_en = 1'b0;
        cyc();
        total++; if (cnt4 !== 4'd1)       begin bad++; $display("FAIL wrap_cnt4 got=%0d want=1", cnt4); end
        total++; if (cycle_cnt !== 32'd17) begin bad++; $display("FAIL wrap_cnt32 got=%0d want=17", cycle_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) run_en = ~run_en;
            if ($urandom_range(0, 5) == 0)  step_req = ~step_req;
            halt_req = ($urandom_range(0, 39) == 0);
            div_load = ($urandom_range(0, 29) == 0);
            div_val  = 16'($urandom_range(0, 4));
            cyc();
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL rand_model k=%0d got=%h want=%h", k, dut_vec, model_vec()); end
        end
        div_load = 1'b0; halt_req = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_free();
        test_step();
        test_halt();
        test_reprogram();
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
